h_s_bsub: RTL and testbench

Bit-serial signed subtractor: computes out = a − b on N-bit two's-complement operands, producing an (N+1)-bit exact signed difference. It uses a single one-bit full-adder cell (`fa`) over N+1 clock cycles, in place of an N-cell ripple chain. It sits alongside the combinational ripple-carry adder family as its sequential, area-minimal counterpart, and is driven by a start/done handshake.

---
 rtl/h_s_bsub.sv | 107 ++++++++++
 tb/tb_h_s_bsub.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/h_s_bsub.sv
// Bit-serial signed subtractor: out = a - b as an exact (N+1)-bit result,
// produced by one full-adder cell stepped over N+1 clock cycles.

module fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));
endmodule

module h_s_bsub #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   out
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [N-1:0]    a_sh_q;
    logic [N-1:0]    b_sh_q;
    logic            c_q;
    logic [CW-1:0]   cnt_q;
    logic [N:0]      res_sh_q;
    logic [N:0]      out_q;
    logic            done_q;
    logic            busy_q;

    logic            fa_y;
    logic            fa_s;
    logic            fa_co;

    // Subtraction as a + ~b + 1: invert the subtrahend bit, carry seeded with 1.
    assign fa_y = ~b_sh_q[0];

    fa u_fa (
        .x   (a_sh_q[0]),
        .y   (fa_y),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            res_sh_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        c_q      <= 1'b1;
                        cnt_q    <= '0;
                        res_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    c_q      <= fa_co;
                    res_sh_q <= {fa_s, res_sh_q[N:1]};
                    // Arithmetic shift: the sign bit feeds the extra (N-th) step.
                    a_sh_q   <= {a_sh_q[N-1], a_sh_q[N-1:1]};
                    b_sh_q   <= {b_sh_q[N-1], b_sh_q[N-1:1]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N)) begin
                        out_q   <= {fa_s, res_sh_q[N:1]};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_h_s_bsub.sv
// Self-checking bench for h_s_bsub: directed cases plus randomized streams
// at N=4 and N=8, checked against plain integer arithmetic.

module tb_h_s_bsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       st4 = 1'b0;
    logic [3:0] a4  = '0;
    logic [3:0] b4  = '0;
    logic       busy4, done4;
    logic [4:0] out4;

    logic       st8 = 1'b0;
    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;
    logic       busy8, done8;
    logic [8:0] out8;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    h_s_bsub #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .out(out4)
    );

    h_s_bsub #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: interpret the low w bits as signed, subtract, keep w+1 bits.
    function automatic int sext(input int w, input int v);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    function automatic int exp_diff(input int w, input int av, input int bv);
        return (sext(w, av) - sext(w, bv)) & ((1 << (w + 1)) - 1);
    endfunction

    function automatic int done_of(input int w);
        return (w == 4) ? int'(done4) : int'(done8);
    endfunction

    function automatic int busy_of(input int w);
        return (w == 4) ? int'(busy4) : int'(busy8);
    endfunction

    function automatic int out_of(input int w);
        return (w == 4) ? int'(out4) : int'(out8);
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input int w, input logic s, input int av, input int bv);
        if (w == 4) begin
            st4 = s; a4 = 4'(av); b4 = 4'(bv);
        end else begin
            st8 = s; a8 = 8'(av); b8 = 8'(bv);
        end
    endtask

    // One isolated operation; operands are scrambled while it runs.
    task automatic op(input int w, input int av, input int bv, input string tag);
        int   cyc;
        logic got;
        logic busy_bad;
        got      = 1'b0;
        busy_bad = 1'b0;
        drive(w, 1'b1, av, bv);
        for (cyc = 1; cyc <= 3 * w; cyc++) begin
            tick;
            drive(w, 1'b0, int'($urandom), int'($urandom));
            if (done_of(w) != 0) begin
                got = 1'b1;
                break;
            end
            if (busy_of(w) != 1) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, cyc, w + 2);
        check({tag, "_busy_run"}, int'(busy_bad), 0);
        check({tag, "_busy_at_done"}, busy_of(w), 0);
        check({tag, "_out"}, out_of(w), exp_diff(w, av, bv));
    endtask

    // Start held high; accepted operands are those present every (w+2)th cycle.
    task automatic stream(input int w, input int npairs, input bit exh, input string tag);
        int p;
        int av;
        int bv;
        int qa[$];
        int qb[$];
        p  = w + 2;
        av = 0;
        bv = 0;
        for (int n = 0; n <= npairs * p; n++) begin
            if (n > 0) begin
                check($sformatf("%s_done_c%0d", tag, n), done_of(w), int'(n % p == 0));
                check($sformatf("%s_busydone_c%0d", tag, n), busy_of(w) & done_of(w), 0);
                if (n % p == 0)
                    check($sformatf("%s_out_c%0d", tag, n), out_of(w),
                          exp_diff(w, qa[n - p], qb[n - p]));
            end
            if (n < npairs * p) begin
                if (exh && (n % p == 0)) begin
                    av = (n / p) >> 4;
                    bv = (n / p) & 15;
                end else begin
                    av = int'($urandom);
                    bv = int'($urandom);
                end
                drive(w, 1'b1, av, bv);
            end else begin
                drive(w, 1'b0, 0, 0);
            end
            qa.push_back(av);
            qb.push_back(bv);
            tick;
        end
    endtask

    initial begin
        int seen;
        @(negedge clk);
        check("rst_busy4", int'(busy4), 0);
        check("rst_done4", int'(done4), 0);
        check("rst_out4", int'(out4), 0);
        check("rst_out8", int'(out8), 0);
        tick;
        rst = 1'b0;
        tick;

        op(4, 5, 3, "p5m3");
        tick;
        check("hold_done_low", int'(done4), 0);
        check("hold_out", int'(out4), 2);

        op(4, -8, 7, "m8m7");
        check("m8m7_lit", int'(out4), 5'b10001);
        op(4, 7, -8, "p7mm8");
        check("p7mm8_lit", int'(out4), 5'b01111);
        op(4, 0, 0, "z_z");
        op(4, -1, -1, "m1_m1");
        op(4, -1, 0, "m1_z");
        check("m1_z_lit", int'(out4), 5'b11111);
        op(8, -128, 127, "n8_min");
        op(8, 127, -128, "n8_max");

        stream(4, 6, 1'b0, "held4");

        // Reset two cycles after accepting 6 - 1.
        op(4, 3, -4, "pre_rst");
        drive(4, 1'b1, 6, 1);
        tick;
        drive(4, 1'b0, 6, 1);
        tick;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        check("abort_out", int'(out4), 0);
        tick;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done4) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_out_kept", int'(out4), 0);
        op(4, 6, 1, "after_rst");
        check("after_rst_lit", int'(out4), 5'b00101);

        stream(4, 256, 1'b1, "sweep4");
        stream(8, 1000, 1'b0, "rand8");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
